// File: rtl/bitwise_stager_pkg.sv
// Shared constants and FSM state type for the bitwise operand stager.
package bitwise_stager_pkg;
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 2;
  localparam int TIMEOUT_MAX   = 255;

  typedef enum logic {
    COLLECT_A = 1'b0,
    COLLECT_B = 1'b1
  } stager_state_e;
endpackage

// File: rtl/operand_pair_fifo.sv
// Circular FIFO of {A,B} operand pairs; head reads as zero when empty.
module operand_pair_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] wr_data,
  input  logic          pop,
  output logic [DW-1:0] rd_data,
  output logic [CW-1:0] count
);
  logic [DEPTH-1:0][DW-1:0] mem;
  logic [AW-1:0]            wptr, rptr;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = (count != '0) ? mem[rptr] : '0;
endmodule

// File: rtl/bitwise_operand_stager.sv
// Pairs an operand byte stream into {A,B} and queues the pairs for a bitwise operator.
// Optional held-A timeout is enabled by defining BITWISE_STAGER_TIMEOUT_EN.
module bitwise_operand_stager
  import bitwise_stager_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_sync,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             pending,
  output logic [CW-1:0]    count,
  output logic             timeout
);
  stager_state_e    state_q, state_d;
  logic [WIDTH-1:0] a_q;
  logic             in_ready_q;
  logic             acc, push, pop, tmo_hit;
  logic [CW-1:0]    cnt_nxt;

  assign in_ready  = in_ready_q;
  assign acc       = in_valid && in_ready_q;
  assign push      = acc && (state_q == COLLECT_B) && !in_sync;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign pending   = (state_q == COLLECT_B);
  // Look ahead one edge so in_ready never lags a push that fills the FIFO.
  assign cnt_nxt   = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= COLLECT_A;
      a_q        <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (cnt_nxt < CW'(DEPTH));
      if (acc && ((state_q == COLLECT_A) || in_sync)) a_q <= in_data;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT_A: if (acc) state_d = COLLECT_B;
      COLLECT_B: if (push || tmo_hit) state_d = COLLECT_A;
      default:   state_d = COLLECT_A;
    endcase
  end

`ifdef BITWISE_STAGER_TIMEOUT_EN
  logic [7:0] tmo_cnt_q;
  logic       timeout_q;

  // Fires on the idle cycle that would take the counter to TIMEOUT_MAX; an accepted beat wins.
  assign tmo_hit = (state_q == COLLECT_B) && !acc && (tmo_cnt_q == 8'(TIMEOUT_MAX - 1));
  assign timeout = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= tmo_hit;
      if (acc && ((state_q == COLLECT_A) || in_sync)) tmo_cnt_q <= '0;
      else if ((state_q == COLLECT_B) && !acc)        tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  operand_pair_fifo #(
    .DW    (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data ({a_q, in_data}),
    .pop     (pop),
    .rd_data ({out_a, out_b}),
    .count   (count)
  );
endmodule

// File: tb/tb_bitwise_operand_stager.sv
// Directed bench for bitwise_operand_stager: drive on negedge, check on the following negedge.
module tb_bitwise_operand_stager;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid, in_sync, in_ready;
  logic [7:0] out_a, out_b;
  logic       out_valid, out_ready, pending, timeout;
  logic [1:0] count;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  bitwise_operand_stager #(.WIDTH(8), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sync   (in_sync),
    .in_ready  (in_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pending   (pending),
    .count     (count),
    .timeout   (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [7:0] d, input logic s);
    in_data  = d;
    in_sync  = s;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_sync  = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_sync = 1'b0; out_ready = 1'b0;
    #3;
    chk("rst_in_ready",  32'(in_ready),  0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_a",     32'(out_a),     0);
    chk("rst_out_b",     32'(out_b),     0);
    chk("rst_pending",   32'(pending),   0);
    chk("rst_count",     32'(count),     0);
    chk("rst_timeout",   32'(timeout),   0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", 32'(in_ready), 1);

    // basic pair, head visible one cycle after B and popped immediately
    out_ready = 1'b1;
    beat(8'h3C, 1'b0);
    chk("basic_pend_a",  32'(pending),   1);
    chk("basic_nv_a",    32'(out_valid), 0);
    beat(8'hA5, 1'b0);
    chk("basic_valid",   32'(out_valid), 1);
    chk("basic_out_a",   32'(out_a),     32'h3C);
    chk("basic_out_b",   32'(out_b),     32'hA5);
    chk("basic_pend_b",  32'(pending),   0);
    @(negedge clk);
    chk("basic_gone",    32'(out_valid), 0);
    chk("basic_zero_a",  32'(out_a),     0);
    out_ready = 1'b0;

    // backpressure to full
    beat(8'h01, 1'b0);
    beat(8'h02, 1'b0);
    chk("bp_cnt1",       32'(count),    1);
    chk("bp_rdy1",       32'(in_ready), 1);
    beat(8'h03, 1'b0);
    beat(8'h04, 1'b0);
    chk("bp_cnt_full",   32'(count),    2);
    chk("bp_rdy_full",   32'(in_ready), 0);
    beat(8'h05, 1'b0);
    chk("bp_5th_rej",    32'(pending),  0);
    chk("bp_cnt_hold",   32'(count),    2);
    chk("bp_head_a",     32'(out_a),    32'h01);
    chk("bp_head_b",     32'(out_b),    32'h02);
    pop_one();
    chk("bp_pop_cnt",    32'(count),    1);
    chk("bp_pop_rdy",    32'(in_ready), 1);
    chk("bp_pop_a",      32'(out_a),    32'h03);
    chk("bp_pop_b",      32'(out_b),    32'h04);
    beat(8'h05, 1'b0);
    beat(8'h06, 1'b0);
    chk("bp_refill",     32'(count),    2);
    pop_one();
    chk("bp_order_a",    32'(out_a),    32'h05);
    chk("bp_order_b",    32'(out_b),    32'h06);
    pop_one();
    chk("bp_empty",      32'(count),    0);
    chk("bp_empty_b",    32'(out_b),    0);

    // resync replaces held A
    beat(8'h11, 1'b1);
    chk("rs_pend1",      32'(pending),  1);
    beat(8'h22, 1'b1);
    chk("rs_pend2",      32'(pending),  1);
    chk("rs_nopush",     32'(count),    0);
    beat(8'h33, 1'b0);
    chk("rs_pend3",      32'(pending),  0);
    chk("rs_cnt",        32'(count),    1);
    chk("rs_a",          32'(out_a),    32'h22);
    chk("rs_b",          32'(out_b),    32'h33);
    pop_one();
    chk("rs_drain",      32'(count),    0);

    // simultaneous push and pop at count=1
    beat(8'hAA, 1'b0);
    beat(8'hBB, 1'b0);
    beat(8'hCC, 1'b0);
    chk("sp_pre_cnt",    32'(count),    1);
    in_data = 8'hDD; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    chk("sp_cnt",        32'(count),    1);
    chk("sp_a",          32'(out_a),    32'hCC);
    chk("sp_b",          32'(out_b),    32'hDD);
    chk("sp_rdy",        32'(in_ready), 1);
    pop_one();
    chk("sp_drain",      32'(count),    0);

    // asynchronous reset mid-pair with a stored pair
    beat(8'h77, 1'b0);
    beat(8'h88, 1'b0);
    beat(8'h55, 1'b0);
    chk("mr_pre_pend",   32'(pending),  1);
    chk("mr_pre_cnt",    32'(count),    1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_pend",       32'(pending),   0);
    chk("mr_cnt",        32'(count),     0);
    chk("mr_valid",      32'(out_valid), 0);
    chk("mr_a",          32'(out_a),     0);
    chk("mr_rdy",        32'(in_ready),  0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("mr_rdy_back",   32'(in_ready),  1);
    chk("mr_no_out",     32'(out_valid), 0);
    beat(8'h66, 1'b0);
    chk("mr_new_a",      32'(pending),   1);
    chk("mr_new_cnt",    32'(count),     0);
    beat(8'h99, 1'b0);
    chk("mr_pair_a",     32'(out_a),     32'h66);
    chk("mr_pair_b",     32'(out_b),     32'h99);
    pop_one();
    chk("tmo_off",       32'(timeout),   0);

`ifdef BITWISE_STAGER_TIMEOUT_EN
    out_ready = 1'b1;
    beat(8'h12, 1'b0);
    repeat (254) @(negedge clk);
    chk("tmo_not_yet",   32'(timeout),   0);
    chk("tmo_still_pend",32'(pending),   1);
    @(negedge clk);
    chk("tmo_pulse",     32'(timeout),   1);
    chk("tmo_pend_clr",  32'(pending),   0);
    chk("tmo_no_pair",   32'(out_valid), 0);
    @(negedge clk);
    chk("tmo_one_cyc",   32'(timeout),   0);
    beat(8'h12, 1'b0);
    repeat (254) @(negedge clk);
    beat(8'h34, 1'b0);
    chk("tmo_b_wins_t",  32'(timeout),   0);
    chk("tmo_b_wins_v",  32'(out_valid), 1);
    chk("tmo_b_wins_a",  32'(out_a),     32'h12);
    chk("tmo_b_wins_b",  32'(out_b),     32'h34);
    @(negedge clk);
    chk("tmo_b_after",   32'(timeout),   0);
    out_ready = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bitwise_operand_stager.md
BITWISE_OPERAND_STAGER -- requirements
Module: bitwise_operand_stager

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8: operand width in bits.
REQ-002 The block SHALL take parameter DEPTH, default 2: operand-pair FIFO entries, a power of two and at least 2.
REQ-003 clk  input  1  the single clock; all state SHALL change on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_data  input  WIDTH  operand byte from the pin-side source.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_sync  input  1  qualifies an accepted beat as operand A and forces resync.
REQ-008 in_ready  output  1  the stager accepts a beat this cycle.
REQ-009 out_a  output  WIDTH  operand A of the FIFO head pair, fed to the bitwise operator's first input.
REQ-010 out_b  output  WIDTH  operand B of the FIFO head pair, fed to the bitwise operator's second input.
REQ-011 out_valid  output  1  the head pair is valid.
REQ-012 out_ready  input  1  the downstream operator consumes the head pair.
REQ-013 pending  output  1  operand A is held and waiting for B.
REQ-014 count  output  $clog2(DEPTH)+1  number of complete pairs in the FIFO.
REQ-015 timeout  output  1  one-cycle pulse when a held A is discarded (see Configuration).

Function
REQ-016 A beat SHALL be accepted when in_valid && in_ready; a pair SHALL be popped when out_valid && out_ready.
REQ-017 The FSM SHALL have two states: COLLECT_A (reset state) and COLLECT_B.
REQ-018 In COLLECT_A, an accepted beat SHALL be latched as A, and the FSM SHALL move to COLLECT_B.
REQ-019 In COLLECT_B, an accepted beat with in_sync=0 SHALL be taken as B, the pair {A,B} SHALL be pushed, and the FSM SHALL return to COLLECT_A.
REQ-020 In COLLECT_B, an accepted beat with in_sync=1 SHALL replace the held A, and the FSM SHALL remain in COLLECT_B (resync; the old A is dropped silently).
REQ-021 in_ready SHALL be the registered value of (count < DEPTH), with no combinational path from out_ready.
REQ-022 A pop SHALL free space visible to in_ready on the next cycle.
REQ-023 When full, in_ready SHALL be 0, whether or not a pop occurs in the same cycle.
REQ-024 Latency: when B is accepted in cycle N with the FIFO empty, out_valid SHALL be 1 in cycle N+1.
REQ-025 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-026 Write and read pointers SHALL wrap modulo DEPTH.
REQ-027 out_a and out_b SHALL hold the head entry while out_valid=1 and out_ready=0; they SHALL be 0 when the FIFO is empty.
REQ-028 pending SHALL equal (state == COLLECT_B).

Reset
REQ-029 While rst_n=0, the block SHALL set state=COLLECT_A, FIFO empty, pointers 0, count 0, out_valid 0, out_a 0, out_b 0, pending 0, timeout 0, in_ready 0.
REQ-030 After release, in_ready SHALL become 1 on the first clock edge.
REQ-031 Reset mid-pair SHALL discard the held A and all stored pairs, with no output activity afterwards.

Configuration
REQ-032 With macro BITWISE_STAGER_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to COLLECT_B or on a resync, and increment each cycle in COLLECT_B with no accepted beat.
REQ-033 On reaching 255, the block SHALL discard A, return to COLLECT_A, and pulse timeout for 1 cycle.
REQ-034 A B beat accepted in the same cycle as the count reaching 255 SHALL win: the pair is pushed and no timeout occurs.
REQ-035 Without the macro, there SHALL be no counter, timeout SHALL be tied to 0, and A SHALL be held indefinitely.

Structure
REQ-036 Package bitwise_stager_pkg SHALL hold the state enum (COLLECT_A, COLLECT_B), TIMEOUT_MAX=255, and the default WIDTH/DEPTH constants.
REQ-037 The FIFO SHALL be sub-module operand_pair_fifo (2*WIDTH wide, DEPTH deep, with count output); the FSM and timeout SHALL stay in the top level.

Verification
REQ-038 Basic pair: after reset, send 0x3C then 0xA5 with out_ready=1 -> out_valid for exactly 1 cycle, with out_a=0x3C and out_b=0xA5, one cycle after B.
REQ-039 Backpressure/full: out_ready=0, send 3 pairs -> count=2, in_ready=0 after the 4th beat, and the 5th beat is not accepted; then pulse out_ready -> pairs pop in order and in_ready returns 1 cycle later.
REQ-040 Resync: send 0x11 (sync=1), 0x22 (sync=1), 0x33 (sync=0) -> single pair {0x22,0x33}, with pending high from the first beat until the pair is pushed.
REQ-041 Simultaneous push/pop at count=1 -> count stays 1, and out_a/out_b advance to the next pair in order.
REQ-042 Mid-pair reset: send A=0x55, assert rst_n=0 asynchronously -> all outputs 0 immediately, and the next beat 0x66 after release is taken as A.
REQ-043 With BITWISE_STAGER_TIMEOUT_EN defined: send A, then idle 255 cycles -> timeout=1 for 1 cycle, pending=0, and no pair; B on exactly cycle 255 -> pair pushed and timeout stays 0.
